// File: rtl/mac_tx_pkg.sv
// Shared types and widths for the MAC transmit arbiter.
package mac_tx_pkg;

   localparam int unsigned MAC_DW   = 32;
   localparam int unsigned MAC_MODW = 2;
   localparam int unsigned CNT_W    = 10;
   localparam int unsigned GAP_W    = 4;
   localparam int unsigned GRANT_W  = 3;
   localparam int unsigned TRUNC_W  = 16;

   typedef enum logic [1:0] {
      StIdle,
      StStream,
      StDrain,
      StGap
   } state_e;

endpackage

// File: rtl/mac_tx_arbiter_if.sv
// Source-side and MAC-side handshake bundle; master is the arbiter, slave the environment.
interface mac_tx_arbiter_if
   import mac_tx_pkg::*;
#(
   parameter int unsigned N_SRC = 4
);

   logic [N_SRC-1:0]          src_valid;
   logic [MAC_DW*N_SRC-1:0]   src_data;
   logic [N_SRC-1:0]          src_sop;
   logic [N_SRC-1:0]          src_eop;
   logic [MAC_MODW*N_SRC-1:0] src_mod;
   logic [N_SRC-1:0]          src_ready;

   logic [MAC_DW-1:0]         tx_data;
   logic                      tx_sop;
   logic                      tx_eop;
   logic                      tx_err;
   logic [MAC_MODW-1:0]       tx_mod;
   logic                      tx_wren;
   logic                      tx_rdy;

   modport master (
      input  src_valid, src_data, src_sop, src_eop, src_mod, tx_rdy,
      output src_ready, tx_data, tx_sop, tx_eop, tx_err, tx_mod, tx_wren
   );

   modport slave (
      output src_valid, src_data, src_sop, src_eop, src_mod, tx_rdy,
      input  src_ready, tx_data, tx_sop, tx_eop, tx_err, tx_mod, tx_wren
   );

endinterface

// File: rtl/mac_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping at N.
module rr_arbiter
   import mac_tx_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]       req,
   input  logic [GRANT_W-1:0] ptr,
   output logic [N-1:0]       gnt,
   output logic [GRANT_W-1:0] idx
);

   int unsigned k;
   logic        found;

   // Scan N positions starting at ptr; the first asserted request wins.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      for (int unsigned i = 0; i < N; i++) begin
         k = (int'(ptr) + i) % N;
         if (!found && req[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            idx    = k[GRANT_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Packet-level round-robin scheduler onto a single registered MAC transmit port.
module mac_tx_arbiter
   import mac_tx_pkg::*;
#(
   parameter int unsigned N_SRC      = 4,
   parameter int unsigned MAX_WORDS  = 384,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   mac_tx_arbiter_if.master   bus,
   output logic               busy,
   output logic [GRANT_W-1:0] grant_id,
   output logic [TRUNC_W-1:0] trunc_count
);

   // With no gap configured a finished packet returns straight to arbitration.
   localparam state_e AFTER_PKT = (GAP_CYCLES == 0) ? StIdle : StGap;

   state_e               state_q, state_d;
   logic [N_SRC-1:0]     req, arb_gnt, src_ready;
   logic [GRANT_W-1:0]   arb_idx, ptr_q, grant_q;
   logic [CNT_W-1:0]     cnt_q, cnt_inc;
   logic [GAP_W-1:0]     gap_q;
   logic [TRUNC_W-1:0]   trunc_q;
   logic                 first_q, src_done_q;
   logic [MAC_DW-1:0]    tx_data_q;
   logic [MAC_MODW-1:0]  tx_mod_q;
   logic                 tx_sop_q, tx_eop_q, tx_err_q, tx_wren_q;
   logic                 any_req, can_load, ready_sel, xfer, trunc_hit;
   logic                 sel_valid, sel_eop;
   logic [MAC_DW-1:0]    sel_data;
   logic [MAC_MODW-1:0]  sel_mod;

   assign req     = bus.src_valid & bus.src_sop;
   assign any_req = |arb_gnt;

   rr_arbiter #(.N(N_SRC)) u_rr_arbiter (
      .req (req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   // Select the granted source's word and fan its ready back out.
   always_comb begin
      sel_valid = 1'b0;
      sel_eop   = 1'b0;
      sel_data  = '0;
      sel_mod   = '0;
      src_ready = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (grant_q == GRANT_W'(i)) begin
            sel_valid    = bus.src_valid[i];
            sel_eop      = bus.src_eop[i];
            sel_data     = bus.src_data[i*MAC_DW +: MAC_DW];
            sel_mod      = bus.src_mod[i*MAC_MODW +: MAC_MODW];
            src_ready[i] = ready_sel;
         end
      end
   end

   assign can_load  = !tx_wren_q || bus.tx_rdy;
   assign xfer      = sel_valid && ready_sel;
   assign cnt_inc   = cnt_q + 1'b1;
   assign trunc_hit = (state_q == StStream) && xfer && !sel_eop &&
                      (cnt_inc == CNT_W'(MAX_WORDS));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic; a packet ends only once the MAC has taken its eop word.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (any_req) state_d = StStream;
         StStream: begin
            if (trunc_hit) state_d = StDrain;
            else if (tx_wren_q && tx_eop_q && bus.tx_rdy) state_d = AFTER_PKT;
         end
         StDrain: if ((src_done_q || (xfer && sel_eop)) && can_load) state_d = AFTER_PKT;
         StGap: if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Source-ready decode; streaming stops accepting once an eop sits in the output register.
   always_comb begin
      ready_sel = 1'b0;
      case (state_q)
         StStream: ready_sel = can_load && !(tx_wren_q && tx_eop_q);
         StDrain:  ready_sel = !src_done_q;
         default:  ready_sel = 1'b0;
      endcase
   end

   // Grant bookkeeping, counters and the registered MAC output word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         grant_q    <= '0;
         cnt_q      <= '0;
         gap_q      <= '0;
         trunc_q    <= '0;
         first_q    <= 1'b0;
         src_done_q <= 1'b0;
         tx_data_q  <= '0;
         tx_mod_q   <= '0;
         tx_sop_q   <= 1'b0;
         tx_eop_q   <= 1'b0;
         tx_err_q   <= 1'b0;
         tx_wren_q  <= 1'b0;
      end else begin
         if (state_q == StIdle && any_req) begin
            grant_q    <= arb_idx;
            ptr_q      <= (arb_idx == GRANT_W'(N_SRC - 1)) ? '0 : arb_idx + 1'b1;
            cnt_q      <= '0;
            first_q    <= 1'b1;
            src_done_q <= 1'b0;
         end
         if (state_q == StStream && xfer) begin
            tx_data_q <= sel_data;
            tx_sop_q  <= first_q;
            tx_wren_q <= 1'b1;
            first_q   <= 1'b0;
            cnt_q     <= cnt_inc;
            if (trunc_hit) begin
               tx_eop_q <= 1'b1;
               tx_err_q <= 1'b1;
               tx_mod_q <= '0;
            end else begin
               tx_eop_q <= sel_eop;
               tx_err_q <= 1'b0;
               tx_mod_q <= sel_mod;
            end
         end else if (bus.tx_rdy) begin
            tx_wren_q <= 1'b0;
         end
         if (trunc_hit && trunc_q != '1) trunc_q <= trunc_q + 1'b1;
         if (state_q == StDrain && xfer && sel_eop) src_done_q <= 1'b1;
         gap_q <= (state_q == StGap) ? gap_q + 1'b1 : '0;
      end
   end

   assign bus.src_ready = src_ready;
   assign bus.tx_data   = tx_data_q;
   assign bus.tx_sop    = tx_sop_q;
   assign bus.tx_eop    = tx_eop_q;
   assign bus.tx_err    = tx_err_q;
   assign bus.tx_mod    = tx_mod_q;
   assign bus.tx_wren   = tx_wren_q;
   assign busy          = (state_q != StIdle);
   assign grant_id      = grant_q;
   assign trunc_count   = trunc_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Scoreboard bench for mac_tx_arbiter: sources feed from queues, a monitor checks MAC words.
module tb_mac_tx_arbiter;
   import mac_tx_pkg::*;

   localparam int unsigned NS   = 4;
   localparam int unsigned MAXW = 384;
   localparam int unsigned GAP  = 2;

   typedef struct packed {
      logic [31:0] data;
      logic        sop;
      logic        eop;
      logic [1:0]  mod;
   } src_word_t;
   typedef logic [39:0] exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        busy;
   logic [2:0]  grant_id;
   logic [15:0] trunc_count;

   mac_tx_arbiter_if #(.N_SRC(NS)) ifc ();

   mac_tx_arbiter #(.N_SRC(NS), .MAX_WORDS(MAXW), .GAP_CYCLES(GAP)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (ifc),
      .busy        (busy),
      .grant_id    (grant_id),
      .trunc_count (trunc_count)
   );

   always #5 clk = ~clk;

   src_word_t src_q [NS][$];
   exp_t      exp_q [$];
   int        n_checks = 0;
   int        n_pass = 0;
   int        acc_cnt = 0;
   int        bubbles = 0;
   int        pkt_id = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endfunction

   function automatic void check_min(string name, int act, int min);
      n_checks++;
      if (act >= min) n_pass++;
      else $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
   endfunction

   function automatic int src_left();
      int n = 0;
      for (int s = 0; s < NS; s++) n += src_q[s].size();
      return n;
   endfunction

   // Queue a packet on source s and push the MAC words it should produce.
   task automatic send_pkt(int s, int n, logic [1:0] m);
      src_word_t  w;
      logic       eo, er;
      logic [1:0] mo;
      for (int k = 0; k < n; k++) begin
         w.data = {8'(s), 8'(pkt_id), 16'(k)};
         w.sop  = (k == 0);
         w.eop  = (k == n - 1);
         w.mod  = w.eop ? m : 2'd0;
         src_q[s].push_back(w);
         if (k < int'(MAXW)) begin
            eo = w.eop;
            er = 1'b0;
            mo = w.mod;
            if (k == int'(MAXW) - 1 && !w.eop) begin
               eo = 1'b1;
               er = 1'b1;
               mo = 2'd0;
            end
            exp_q.push_back({3'(s), w.data, w.sop, eo, er, mo});
         end
      end
      pkt_id++;
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_wren"},  64'(ifc.tx_wren), 0);
      check({tag, "_sop"},   64'(ifc.tx_sop), 0);
      check({tag, "_eop"},   64'(ifc.tx_eop), 0);
      check({tag, "_err"},   64'(ifc.tx_err), 0);
      check({tag, "_data"},  64'(ifc.tx_data), 0);
      check({tag, "_mod"},   64'(ifc.tx_mod), 0);
      check({tag, "_ready"}, 64'(ifc.src_ready), 0);
      check({tag, "_busy"},  64'(busy), 0);
      check({tag, "_gid"},   64'(grant_id), 0);
      check({tag, "_trunc"}, 64'(trunc_count), 0);
   endtask

   task automatic flush();
      exp_q.delete();
      for (int s = 0; s < NS; s++) src_q[s].delete();
      ifc.src_valid = '0;
      ifc.src_sop   = '0;
      ifc.src_eop   = '0;
   endtask

   task automatic do_reset(bit chk);
      rst_n = 1'b0;
      #1;
      if (chk) check_reset_outputs("rst");
      flush();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_acc(int target, int budget);
      int c = 0;
      while (acc_cnt < target && c < budget) begin
         @(negedge clk);
         c++;
      end
      check_min("wait_words", acc_cnt, target);
   endtask

   task automatic wait_done(string name, int budget);
      int c = 0;
      while (c < budget && !(exp_q.size() == 0 && src_left() == 0 && !busy)) begin
         @(negedge clk);
         c++;
      end
      check({"done_", name}, 64'(exp_q.size()) + 64'(src_left()), 0);
      check({"idle_", name}, 64'(busy), 0);
   endtask

   // Source driver: retire handshaken words, then present each queue head.
   initial begin
      logic [NS-1:0] hs;
      ifc.src_valid = '0;
      ifc.src_data  = '0;
      ifc.src_sop   = '0;
      ifc.src_eop   = '0;
      ifc.src_mod   = '0;
      forever begin
         @(negedge clk);
         hs = ifc.src_valid & ifc.src_ready;
         @(posedge clk);
         #1;
         for (int s = 0; s < NS; s++) begin
            if (hs[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
            if (src_q[s].size() > 0) begin
               ifc.src_valid[s]        = 1'b1;
               ifc.src_data[s*32 +: 32] = src_q[s][0].data;
               ifc.src_sop[s]          = src_q[s][0].sop;
               ifc.src_eop[s]          = src_q[s][0].eop;
               ifc.src_mod[s*2 +: 2]   = src_q[s][0].mod;
            end else begin
               ifc.src_valid[s] = 1'b0;
               ifc.src_sop[s]   = 1'b0;
               ifc.src_eop[s]   = 1'b0;
            end
         end
      end
   end

   // Monitor: scoreboard compare, stall hold, inter-packet gap and mid-packet bubbles.
   logic [37:0] obs, prev_obs;
   logic        prev_stall = 1'b0;
   logic        in_pkt = 1'b0;
   logic        have_eop = 1'b0;
   int          idle = 0;
   exp_t        e;
   initial begin
      forever begin
         @(negedge clk);
         obs = {ifc.tx_wren, ifc.tx_data, ifc.tx_sop, ifc.tx_eop, ifc.tx_err, ifc.tx_mod};
         if (!rst_n) begin
            prev_stall = 1'b0;
            in_pkt     = 1'b0;
            have_eop   = 1'b0;
            idle       = 0;
         end else begin
            if (prev_stall) check("stall_hold", 64'(obs), 64'(prev_obs));
            if (ifc.tx_wren && !ifc.tx_rdy) check("stall_ready", 64'(ifc.src_ready), 0);
            if (in_pkt && !ifc.tx_wren) bubbles++;
            if (ifc.tx_wren && ifc.tx_rdy) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  $display("FAIL extra_word: got %0h, expected no word", obs);
               end else begin
                  e = exp_q.pop_front();
                  check("word", 64'({grant_id, ifc.tx_data, ifc.tx_sop, ifc.tx_eop,
                                     ifc.tx_err, ifc.tx_mod}), 64'(e));
               end
               if (ifc.tx_sop && have_eop) check_min("gap_idle", idle, GAP + 1);
               in_pkt = !ifc.tx_eop;
               if (ifc.tx_eop) begin
                  have_eop = 1'b1;
                  idle     = 0;
               end
               acc_cnt++;
            end else if (!ifc.tx_wren) begin
               idle++;
            end
            prev_stall = ifc.tx_wren && !ifc.tx_rdy;
            prev_obs   = obs;
         end
      end
   end

   initial begin
      int base;
      ifc.tx_rdy = 1'b1;
      #2;
      do_reset(1'b1);

      // 52-word packet from source 0.
      send_pkt(0, 52, 2'd2);
      wait_done("single52", 1000);

      // Two round-robin rounds of 4-word packets.
      do_reset(1'b0);
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < NS; s++) send_pkt(s, 4, 2'd1);
      wait_done("rr", 1000);

      // MAC back-pressure 1,0,0,1 mid-packet.
      do_reset(1'b0);
      base = acc_cnt;
      send_pkt(2, 12, 2'd3);
      wait_acc(base + 4, 200);
      @(posedge clk);
      #1 ifc.tx_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1 ifc.tx_rdy = 1'b1;
      wait_done("stall", 500);

      // Runaway 400-word packet truncated at 384, then a normal packet.
      do_reset(1'b0);
      send_pkt(1, 400, 2'd2);
      send_pkt(2, 4, 2'd1);
      wait_done("trunc", 2000);
      check("trunc_count", 64'(trunc_count), 1);

      // Reset mid-packet, then a lone requester on source 2.
      do_reset(1'b0);
      base = acc_cnt;
      send_pkt(0, 30, 2'd1);
      wait_acc(base + 10, 300);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check_reset_outputs("midrst");
      flush();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      send_pkt(2, 5, 2'd1);
      wait_done("after_rst", 300);

      // Single-word packet with an immediate re-request.
      do_reset(1'b0);
      send_pkt(3, 1, 2'd3);
      send_pkt(3, 3, 2'd0);
      wait_done("oneword", 300);

      check("no_bubbles", 64'(bubbles), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mac_tx_arbiter.md
# mac_tx_arbiter

Packet-level scheduler that shares the single MAC transmit FIFO interface (32-bit data, sop/eop/err/mod, wren/rdy) between N_SRC packet sources such as per-channel sample packetizers. Grants whole packets round-robin. Registers all MAC-side outputs and enforces a minimum inter-packet idle gap. Truncates runaway packets with an error-flagged eop so one faulty source cannot lock the MAC.

## Interface
- N_SRC, 4, number of requesting sources (2..8)
- MAX_WORDS, 384, maximum 32-bit words per packet; must be ≥2
- GAP_CYCLES, 2, minimum idle cycles on the MAC interface after each packet (0..15)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- src_valid  in  N_SRC  per-source word valid
- src_data  in  32*N_SRC  per-source word; source i occupies bits [32i+31:32i], byte 0 in [31:24]
- src_sop  in  N_SRC  first word of packet
- src_eop  in  N_SRC  last word of packet
- src_mod  in  2*N_SRC  invalid trailing bytes in the eop word
- src_ready  out  N_SRC  per-source word accept
- tx_data  out  32  MAC data
- tx_sop  out  1  MAC start of packet
- tx_eop  out  1  MAC end of packet
- tx_err  out  1  MAC packet error; set only on a truncated eop
- tx_mod  out  2  MAC empty-byte count
- tx_wren  out  1  MAC word valid
- tx_rdy  in  1  MAC ready
- busy  out  1  state ≠ IDLE
- grant_id  out  3  index of the current or most recent grant
- trunc_count  out  16  truncated packets, saturating at 16'hFFFF

## Operation
- Source handshake: a word transfers when src_valid[i] & src_ready[i].
- MAC handshake: a word transfers when tx_wren & tx_rdy. While tx_wren=1 and tx_rdy=0, all tx_* outputs hold stable.
- Request: req[i] = src_valid[i] & src_sop[i]. A source with valid but no sop is never granted.
- States:
  - IDLE: if any req, latch a winner from rr_arbiter and go to STREAM. Pointer moves to winner+1 mod N_SRC. Pointer resets to 0.
  - STREAM: src_ready[g] = (!tx_wren | tx_rdy); all other src_ready are 0. Each accepted source word loads the output register with tx_wren=1. tx_sop is set only on the first word; a mid-packet src_sop is forwarded as 0.
    - A 10-bit word counter increments per load.
    - If an eop word is loaded, stop accepting. Once the MAC accepts that word, go to GAP.
  - Truncation: if the word loaded when count reaches MAX_WORDS has src_eop=0, force tx_eop=1, tx_err=1, tx_mod=0, increment trunc_count, and go to DRAIN.
  - DRAIN: src_ready[g]=1; accepted words are discarded. On src_eop accepted, go to GAP once the MAC has accepted the truncated eop.
  - GAP: tx_wren=0 for GAP_CYCLES cycles, then IDLE. With GAP_CYCLES=0, go straight to IDLE.
- When the output register drains with no new word loaded, tx_wren=0 and the other tx_* outputs keep their last values.

## Timing
- Reset: tx_wren, tx_sop, tx_eop, tx_err=0; tx_data=0; tx_mod=0; src_ready=0; busy=0; grant_id=0; trunc_count=0; state IDLE.
- Reset mid-packet aborts immediately with no eop emitted; the MAC is responsible for discarding the partial frame.
- Request seen in IDLE at edge t: STREAM with src_ready at t+1; first tx_wren at t+2.
- Throughput is 1 word/cycle while tx_rdy=1. Back-to-back packets are separated by ≥GAP_CYCLES+1 idle cycles (one for IDLE arbitration).
- A single-word packet (sop&eop) is legal and passes with tx_sop=tx_eop=1.
- A packet of exactly MAX_WORDS words ending in eop is not truncated.

## Structure
- Package mac_tx_pkg holds:
  - state encoding (IDLE, STREAM, DRAIN, GAP)
  - MAC_DW=32 and MAC_MODW=2
  - counter widths
- Sub-module rr_arbiter: parameter N; inputs req and pointer; outputs a one-hot grant and an index. Combinational; the pointer register lives in the parent.

## Test plan
- Single source 0 sends 52 words (sop on word 0, eop on word 51, mod=2) with tx_rdy=1 → 52 consecutive tx_wren cycles, tx_sop on the first, tx_eop & tx_mod=2 on the last, tx_err=0, data order preserved.
- Sources 0..3 request simultaneously, 4-word packets each → grants in order 0,1,2,3 with ≥3 idle cycles between packets at GAP_CYCLES=2; a repeat round starts again at 0.
- tx_rdy toggled 1,0,0,1 during a packet → tx_* held stable during the low cycles; no words lost or duplicated; src_ready low while stalled.
- Source 1 sends 400 words with eop at 400, MAX_WORDS=384 → word 384 is output with eop=1, err=1, mod=0; words 385–400 are absorbed; trunc_count=1; the next grant proceeds normally.
- rst_n pulled low mid-packet at word 10 → all outputs 0 immediately; after release, a new sop from source 2 is granted first (pointer 0, only requester).
- Single-word packet (sop=eop=1) followed by an immediate re-request → output tx_sop=tx_eop=1 in one cycle; the next packet's tx_wren comes ≥GAP_CYCLES+1 cycles later.
